// File: rtl/audio_bridge_pkg.sv
// Shared types and defaults for the ARM-to-AC97 playback sample bridge.
package audio_bridge_pkg;

    localparam int SAMPLE_W        = 16;
    localparam int SLOT_W          = 20;
    localparam int PAIR_W          = 2 * SAMPLE_W;
    localparam int DEF_DEPTH       = 64;
    localparam int DEF_PRIME_LEVEL = 8;
    localparam int DEF_LOW_WATER   = 16;

    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_PRIME    = 2'd1,
        ST_RUN      = 2'd2
    } bridge_state_t;

    // Stereo pair as written by the ARM: left in the upper half.
    typedef struct packed {
        logic signed [SAMPLE_W-1:0] left;
        logic signed [SAMPLE_W-1:0] right;
    } sample_pair_t;

    // AC97 slots are 20 bits, MSB-aligned; 16-bit PCM gets four zero LSBs.
    function automatic logic [SLOT_W-1:0] to_slot(input logic [SAMPLE_W-1:0] s);
        return {s, {(SLOT_W - SAMPLE_W){1'b0}}};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous-read RAM: read data appears one cycle after rd_en.
// Pushes while full and pops while empty are ignored; flush empties it and wins over both.
module sync_fifo #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             push;
    logic             pop;

    // Pointers carry one extra MSB so full and empty differ only by that bit.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level = wr_ptr - rd_ptr;

    assign push = wr_en && !full && !flush;
    assign pop  = rd_en && !empty && !flush;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage is left unreset; only popped words are ever observed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
        if (pop) begin
            rd_data <= mem[rd_ptr[AW-1:0]];
        end
    end

endmodule

// File: rtl/audio_sample_bridge.sv
// ARM push FIFO feeding AC97 slots 3/4; each accepted frame_req yields sample_valid 2 cycles later.
// No backpressure: pushes into a full FIFO drop and flag overflow, requests on empty return zeros.
module audio_sample_bridge
    import audio_bridge_pkg::*;
#(
    parameter int DEPTH       = DEF_DEPTH,
    parameter int PRIME_LEVEL = DEF_PRIME_LEVEL,
    parameter int LOW_WATER   = DEF_LOW_WATER
) (
    input  logic                   SYS_CLK,
    input  logic                   SYS_RST_N,
    input  logic                   enable,
    input  logic                   wr_en,
    input  logic [PAIR_W-1:0]      wr_data,
    input  logic                   frame_req,
    input  logic                   clr_status,
    output logic [SLOT_W-1:0]      left_sample,
    output logic [SLOT_W-1:0]      right_sample,
    output logic                   sample_valid,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic                   fifo_full,
    output logic                   underrun,
    output logic                   overflow,
    output logic                   irq_low_water
);

    localparam int                LVL_W     = $clog2(DEPTH) + 1;
    localparam logic [LVL_W-1:0]  PRIME_LVL = LVL_W'(PRIME_LEVEL);
    localparam logic [LVL_W-1:0]  LOW_LVL   = LVL_W'(LOW_WATER);

    bridge_state_t     state;
    logic              flush;
    logic              req_ok;
    logic              pop;
    logic              starve;
    logic              ovf_evt;
    logic              req_p1;
    logic              pop_p1;
    logic              fifo_empty;
    logic [PAIR_W-1:0] fifo_rd_data;
    sample_pair_t      rd_pair;

    // Leaving any active state empties the FIFO; staying disabled does not,
    // so the ARM may pre-load samples before enabling playback.
    assign flush   = !enable && (state != ST_DISABLED);

    // One request in flight at a time: blocked until its sample_valid has gone out.
    assign req_ok  = frame_req && !flush && !req_p1 && !sample_valid;
    assign pop     = req_ok && (state == ST_RUN) && !fifo_empty;
    assign starve  = req_ok && (state == ST_RUN) && fifo_empty;
    assign ovf_evt = wr_en && !flush && fifo_full;
    assign rd_pair = sample_pair_t'(fifo_rd_data);

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (PAIR_W)
    ) u_fifo (
        .clk     (SYS_CLK),
        .rst_n   (SYS_RST_N),
        .flush   (flush),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .level   (fifo_level),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge SYS_CLK) begin
        if (!SYS_RST_N) begin
            state         <= ST_DISABLED;
            req_p1        <= 1'b0;
            pop_p1        <= 1'b0;
            sample_valid  <= 1'b0;
            left_sample   <= '0;
            right_sample  <= '0;
            underrun      <= 1'b0;
            overflow      <= 1'b0;
            irq_low_water <= 1'b0;
        end else begin
            // Stage 1: RAM read in progress; stage 2: slot registers load.
            req_p1       <= req_ok;
            pop_p1       <= pop;
            sample_valid <= req_p1 && !flush;
            if (req_p1 && !flush) begin
                left_sample  <= pop_p1 ? to_slot(rd_pair.left)  : '0;
                right_sample <= pop_p1 ? to_slot(rd_pair.right) : '0;
            end

            if (starve) begin
                underrun <= 1'b1;
            end else if (clr_status) begin
                underrun <= 1'b0;
            end

            if (ovf_evt) begin
                overflow <= 1'b1;
            end else if (clr_status) begin
                overflow <= 1'b0;
            end

            irq_low_water <= (state != ST_DISABLED) && (fifo_level < LOW_LVL);

            if (!enable) begin
                state <= ST_DISABLED;
            end else begin
                case (state)
                    ST_DISABLED: state <= ST_PRIME;
                    ST_PRIME:    if (fifo_level >= PRIME_LVL) state <= ST_RUN;
                    ST_RUN:      if (starve) state <= ST_PRIME;
                    default:     state <= ST_DISABLED;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_audio_sample_bridge.sv
// Bench for audio_sample_bridge: vector table, directed corner sequences and a random run
// checked every cycle against a queue-based reference model.
module tb_audio_sample_bridge;

    localparam int DEPTH   = 64;
    localparam int PRIME   = 8;
    localparam int LOW     = 16;
    localparam int M_DIS   = 0;
    localparam int M_PRIME = 1;
    localparam int M_RUN   = 2;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        en    = 1'b0;
    logic        we    = 1'b0;
    logic        fr    = 1'b0;
    logic        clr   = 1'b0;
    logic [31:0] wd    = '0;

    logic [19:0] left_sample;
    logic [19:0] right_sample;
    logic        sample_valid;
    logic [6:0]  fifo_level;
    logic        fifo_full;
    logic        underrun;
    logic        overflow;
    logic        irq_low_water;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    audio_sample_bridge #(
        .DEPTH       (DEPTH),
        .PRIME_LEVEL (PRIME),
        .LOW_WATER   (LOW)
    ) dut (
        .SYS_CLK       (clk),
        .SYS_RST_N     (rst_n),
        .enable        (en),
        .wr_en         (we),
        .wr_data       (wd),
        .frame_req     (fr),
        .clr_status    (clr),
        .left_sample   (left_sample),
        .right_sample  (right_sample),
        .sample_valid  (sample_valid),
        .fifo_level    (fifo_level),
        .fifo_full     (fifo_full),
        .underrun      (underrun),
        .overflow      (overflow),
        .irq_low_water (irq_low_water)
    );

    // Reference model: a sample queue plus the observable status, advanced once per clock.
    logic [31:0] mq[$];
    int          m_st   = M_DIS;
    int          m_last = -100;
    int          cyc    = 0;
    bit          m_pend = 1'b0;
    logic [19:0] m_pl   = '0;
    logic [19:0] m_pr   = '0;
    bit          m_vld  = 1'b0;
    logic [19:0] m_l    = '0;
    logic [19:0] m_r    = '0;
    bit          m_unr  = 1'b0;
    bit          m_ovf  = 1'b0;
    bit          m_irq  = 1'b0;

    task automatic model_step();
        int          sz;
        bit          flush;
        bit          accept;
        bit          starve;
        bit          ovf_evt;
        logic [31:0] p;
        if (!rst_n) begin
            m_st = M_DIS; mq.delete(); m_pend = 0; m_vld = 0; m_l = '0; m_r = '0;
            m_unr = 0; m_ovf = 0; m_irq = 0; m_last = -100;
        end else begin
            sz    = mq.size();
            flush = !en && (m_st != M_DIS);
            m_irq = (m_st != M_DIS) && (sz < LOW);
            m_vld = m_pend && !flush;
            if (m_vld) begin
                m_l = m_pl;
                m_r = m_pr;
            end
            m_pend = 0;
            accept = fr && !flush && (cyc - m_last >= 3);
            starve = 0;
            if (accept) begin
                m_last = cyc; m_pend = 1; m_pl = '0; m_pr = '0;
                if (m_st == M_RUN) begin
                    if (sz > 0) begin
                        p    = mq.pop_front();
                        m_pl = {p[31:16], 4'h0};
                        m_pr = {p[15:0], 4'h0};
                    end else begin
                        starve = 1;
                    end
                end
            end
            ovf_evt = we && !flush && (sz == DEPTH);
            if (we && !flush && sz < DEPTH) mq.push_back(wd);
            if (starve) m_unr = 1; else if (clr) m_unr = 0;
            if (ovf_evt) m_ovf = 1; else if (clr) m_ovf = 0;
            if (flush) begin
                mq.delete();
                m_last = -100;
            end
            if (!en) m_st = M_DIS;
            else if (m_st == M_DIS) m_st = M_PRIME;
            else if (m_st == M_PRIME && sz >= PRIME) m_st = M_RUN;
            else if (m_st == M_RUN && starve) m_st = M_PRIME;
        end
        cyc++;
    endtask

    function automatic logic [51:0] dut_vec();
        return {sample_valid, left_sample, right_sample, fifo_level,
                fifo_full, underrun, overflow, irq_low_water};
    endfunction

    function automatic logic [51:0] model_vec();
        return {m_vld, m_l, m_r, 7'(mq.size()),
                mq.size() == DEPTH, m_unr, m_ovf, m_irq};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("model", 64'(dut_vec()), 64'(model_vec()));
    endtask

    task automatic step(input bit w, input logic [31:0] d, input bit f, input bit c);
        we = w; wd = d; fr = f; clr = c;
        tick();
        we = 0; fr = 0; clr = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, 0, 0);
    endtask

    task automatic do_reset();
        rst_n = 0; en = 0;
        idle(2);
        rst_n = 1;
    endtask

    function automatic logic [31:0] pair(input int i);
        logic [15:0] a;
        logic [15:0] b;
        a = 16'h1234 + 16'(i);
        b = 16'hFEDC - 16'(i);
        return {a, b};
    endfunction

    typedef struct {
        bit          en;
        bit          we;
        bit          fr;
        bit          clr;
        logic [31:0] wd;
        bit          vld;
        logic [19:0] l;
        logic [19:0] r;
        logic [6:0]  lvl;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input bit e, input bit w, input bit f, input bit c,
                                input logic [31:0] d, input bit v,
                                input logic [19:0] l, input logic [19:0] r,
                                input logic [6:0] lv);
        vec_t x;
        x.en = e; x.we = w; x.fr = f; x.clr = c; x.wd = d;
        x.vld = v; x.l = l; x.r = r; x.lvl = lv;
        return x;
    endfunction

    initial begin
        int          wp;
        logic [15:0] a;
        logic [15:0] b;

        // Reset state and basic prime/run/pop behaviour from a vector table.
        do_reset();
        check("reset_state", 64'(dut_vec()), 64'(0));

        tbl.push_back(mk(1, 0, 0, 0, '0, 0, '0, '0, 7'd0));
        for (int i = 0; i < 8; i++) tbl.push_back(mk(1, 1, 0, 0, pair(i), 0, '0, '0, 7'(i + 1)));
        tbl.push_back(mk(1, 0, 0, 0, '0, 0, '0, '0, 7'd8));
        tbl.push_back(mk(1, 0, 1, 0, '0, 0, '0, '0, 7'd7));
        tbl.push_back(mk(1, 0, 0, 0, '0, 1, 20'h12340, 20'hFEDC0, 7'd7));
        tbl.push_back(mk(1, 0, 0, 0, '0, 0, 20'h12340, 20'hFEDC0, 7'd7));
        tbl.push_back(mk(1, 0, 1, 0, '0, 0, 20'h12340, 20'hFEDC0, 7'd6));
        tbl.push_back(mk(1, 0, 1, 0, '0, 1, 20'h12350, 20'hFEDB0, 7'd6));
        tbl.push_back(mk(1, 0, 1, 0, '0, 0, 20'h12350, 20'hFEDB0, 7'd6));
        tbl.push_back(mk(1, 0, 1, 0, '0, 0, 20'h12350, 20'hFEDB0, 7'd5));
        tbl.push_back(mk(1, 0, 0, 0, '0, 1, 20'h12360, 20'hFEDA0, 7'd5));
        for (int i = 0; i < tbl.size(); i++) begin
            en = tbl[i].en;
            step(tbl[i].we, tbl[i].wd, tbl[i].fr, tbl[i].clr);
            check($sformatf("vec%0d", i),
                  64'({sample_valid, left_sample, right_sample, fifo_level}),
                  64'({tbl[i].vld, tbl[i].l, tbl[i].r, tbl[i].lvl}));
        end

        // Underrun on the last entry, sticky flag clear, fall back to prime.
        do_reset(); en = 1; idle(1);
        for (int i = 0; i < 8; i++) step(1, pair(i), 0, 0);
        idle(2);
        for (int i = 0; i < 7; i++) begin
            step(0, '0, 1, 0);
            idle(2);
        end
        check("one_left", 64'(fifo_level), 64'(1));
        step(0, '0, 1, 0);
        step(0, '0, 0, 0);
        check("last_data", 64'({sample_valid, left_sample, right_sample}), 64'({1'b1, 20'h123B0, 20'hFED50}));
        idle(8);
        step(0, '0, 1, 0);
        check("underrun_set", 64'(underrun), 64'(1));
        step(0, '0, 0, 0);
        check("underrun_zeros", 64'({sample_valid, left_sample, right_sample}), 64'({1'b1, 20'h0, 20'h0}));
        step(0, '0, 0, 1);
        check("underrun_clr", 64'(underrun), 64'(0));
        step(0, '0, 1, 0);
        step(0, '0, 0, 0);
        check("prime_after_underrun", 64'({sample_valid, left_sample, underrun}), 64'({1'b1, 20'h0, 1'b0}));

        // Overflow: 65 pushes into a 64-deep FIFO, then drain in order.
        do_reset(); en = 1; idle(1);
        for (int i = 0; i < 65; i++) begin
            a = 16'(i); b = 16'hFFFF - a;
            step(1, {a, b}, 0, 0);
        end
        check("full_ovf", 64'({fifo_level, fifo_full, overflow}), 64'({7'd64, 1'b1, 1'b1}));
        for (int i = 0; i < 64; i++) begin
            a = 16'(i); b = 16'hFFFF - a;
            step(0, '0, 1, 0);
            step(0, '0, 0, 0);
            check($sformatf("drain%0d", i), 64'({sample_valid, left_sample, right_sample}),
                  64'({1'b1, a, 4'h0, b, 4'h0}));
            step(0, '0, 0, 0);
        end
        step(0, '0, 1, 0);
        check("drained_underrun", 64'(underrun), 64'(1));
        step(0, '0, 0, 0);
        check("no_65th", 64'({sample_valid, left_sample}), 64'({1'b1, 20'h0}));

        // Simultaneous push and pop; low-water threshold edges.
        do_reset(); en = 1; idle(1);
        for (int i = 0; i < 10; i++) step(1, pair(i), 0, 0);
        idle(1);
        check("level10", 64'(fifo_level), 64'(10));
        step(1, 32'hA5A5_5A5A, 1, 0);
        check("push_pop_level", 64'(fifo_level), 64'(10));
        for (int i = 0; i < 5; i++) step(1, pair(i), 0, 0);
        idle(1);
        check("irq_at_15", 64'({irq_low_water, fifo_level}), 64'({1'b1, 7'd15}));
        step(1, pair(9), 0, 0);
        idle(1);
        check("irq_at_16", 64'({irq_low_water, fifo_level}), 64'({1'b0, 7'd16}));

        // Disable with a request in flight flushes and suppresses sample_valid.
        do_reset(); en = 1; idle(1);
        for (int i = 0; i < 20; i++) step(1, pair(i), 0, 0);
        idle(2);
        step(0, '0, 1, 0);
        en = 0;
        step(0, '0, 0, 0);
        check("flush_level", 64'({sample_valid, fifo_level}), 64'({1'b0, 7'd0}));
        step(0, '0, 0, 0);
        check("flush_no_valid", 64'(sample_valid), 64'(0));
        en = 1;
        idle(1);
        step(1, pair(3), 0, 0);
        step(0, '0, 1, 0);
        step(0, '0, 0, 0);
        check("reenable_prime", 64'({sample_valid, left_sample, right_sample, fifo_level}),
              64'({1'b1, 20'h0, 20'h0, 7'd1}));

        // Reset pulse while a request is in the pipeline.
        do_reset(); en = 1; idle(1);
        for (int i = 0; i < 8; i++) step(1, pair(i), 0, 0);
        idle(2);
        step(0, '0, 1, 0);
        idle(2);
        step(0, '0, 1, 0);
        rst_n = 0;
        step(0, '0, 0, 0);
        check("mid_reset", 64'(dut_vec()), 64'(0));
        rst_n = 1;
        step(0, '0, 0, 0);
        check("mid_reset_no_valid", 64'(sample_valid), 64'(0));

        // Random traffic against the model, with phases of light and heavy pushing.
        do_reset(); en = 1;
        wp = 20;
        for (int n = 0; n < 4000; n++) begin
            if (n % 500 == 0) wp = (n / 500 % 3 == 0) ? 20 : ((n / 500 % 3 == 1) ? 85 : 50);
            if ($urandom_range(0, 199) == 0) en = ~en;
            else if (!en && $urandom_range(0, 9) == 0) en = 1;
            rst_n = ($urandom_range(0, 799) != 0);
            step($urandom_range(0, 99) < wp, $urandom, $urandom_range(0, 99) < 40,
                 $urandom_range(0, 99) < 4);
        end
        rst_n = 1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
